// File: rtl/fmps_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one FMPS Aurora TX AXI-Stream link between
// several sources; gates on channel-up, flushes cut packets and counts packets per FA cycle.
module fmps_tx_arbiter #(
    parameter int NUM_SOURCES = 2,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                      auroraUserClk,
    input  logic                      auroraReset,
    input  logic                      auroraFAstrobe,
    input  logic                      auroraChannelUp,
    input  logic [32*NUM_SOURCES-1:0] srcTDATA,
    input  logic [NUM_SOURCES-1:0]    srcTVALID,
    input  logic [NUM_SOURCES-1:0]    srcTLAST,
    output logic [NUM_SOURCES-1:0]    srcTREADY,
    output logic [31:0]               FMPS_TEST_AXI_STREAM_TX_tdata,
    output logic                      FMPS_TEST_AXI_STREAM_TX_tvalid,
    output logic                      FMPS_TEST_AXI_STREAM_TX_tlast,
    input  logic                      FMPS_TEST_AXI_STREAM_TX_tready,
    output logic [NUM_SOURCES-1:0]    grant,
    output logic [CNT_WIDTH-1:0]      packetsLastCycle,
    output logic [CNT_WIDTH-1:0]      abortCount
);
    localparam int PTR_W = $clog2(NUM_SOURCES);

    typedef enum logic [1:0] {IDLE, SEND, FLUSH} state_t;

    state_t               state;
    state_t               nextState;
    logic [PTR_W-1:0]     rrPointer;
    logic [PTR_W-1:0]     winnerIdx;
    logic [PTR_W-1:0]     cand;
    logic [CNT_WIDTH-1:0] pktCount;
    logic [31:0]          srcWord [NUM_SOURCES];
    logic                 ownValid;
    logic                 ownLast;
    logic                 pktDone;
    logic                 pktAbort;

    function automatic logic [CNT_WIDTH-1:0] satInc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_SOURCES; i++) begin
            srcWord[i] = srcTDATA[32*i +: 32];
        end
    end

    // rrPointer always holds the current (or most recent) owner, so it doubles as the mux select.
    assign ownValid = srcTVALID[rrPointer];
    assign ownLast  = srcTLAST[rrPointer];
    assign pktDone  = (state == SEND) && auroraChannelUp && ownValid && ownLast
                      && FMPS_TEST_AXI_STREAM_TX_tready;
    assign pktAbort = (state == SEND) && !auroraChannelUp;

    // Scan downwards so the last hit is the first requester after rrPointer.
    always_comb begin
        winnerIdx = rrPointer;
        cand      = '0;
        for (int k = NUM_SOURCES; k >= 1; k--) begin
            cand = PTR_W'((int'(rrPointer) + k) % NUM_SOURCES);
            if (srcTVALID[cand]) begin
                winnerIdx = cand;
            end
        end
    end

    always_ff @(posedge auroraUserClk or posedge auroraReset) begin
        if (auroraReset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (auroraChannelUp && (|srcTVALID)) begin
                    nextState = SEND;
                end
            end
            SEND: begin
                if (!auroraChannelUp) begin
                    nextState = (ownValid && ownLast) ? IDLE : FLUSH;
                end else if (pktDone) begin
                    nextState = IDLE;
                end
            end
            FLUSH: begin
                if (ownValid && ownLast) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // On channel loss the owner is drained immediately so the cut word is never replayed.
    always_comb begin
        srcTREADY                      = '0;
        FMPS_TEST_AXI_STREAM_TX_tdata  = '0;
        FMPS_TEST_AXI_STREAM_TX_tvalid = 1'b0;
        FMPS_TEST_AXI_STREAM_TX_tlast  = 1'b0;
        case (state)
            IDLE: begin
                if (!auroraChannelUp) begin
                    srcTREADY = '1;
                end
            end
            SEND: begin
                FMPS_TEST_AXI_STREAM_TX_tdata  = srcWord[rrPointer];
                FMPS_TEST_AXI_STREAM_TX_tlast  = ownLast;
                FMPS_TEST_AXI_STREAM_TX_tvalid = ownValid && auroraChannelUp;
                srcTREADY[rrPointer] = auroraChannelUp ? FMPS_TEST_AXI_STREAM_TX_tready : 1'b1;
            end
            FLUSH: begin
                srcTREADY[rrPointer] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge auroraUserClk or posedge auroraReset) begin
        if (auroraReset) begin
            grant     <= '0;
            rrPointer <= PTR_W'(NUM_SOURCES - 1);
        end else if ((state == IDLE) && (nextState == SEND)) begin
            grant     <= NUM_SOURCES'(1) << winnerIdx;
            rrPointer <= winnerIdx;
        end else if (nextState == IDLE) begin
            grant <= '0;
        end
    end

    // A packet finishing on the strobe cycle belongs to the new interval.
    always_ff @(posedge auroraUserClk or posedge auroraReset) begin
        if (auroraReset) begin
            pktCount         <= '0;
            packetsLastCycle <= '0;
            abortCount       <= '0;
        end else begin
            if (auroraFAstrobe) begin
                packetsLastCycle <= pktCount;
                pktCount         <= pktDone ? CNT_WIDTH'(1) : '0;
            end else if (pktDone) begin
                pktCount <= satInc(pktCount);
            end
            if (pktAbort) begin
                abortCount <= satInc(abortCount);
            end
        end
    end

endmodule

// File: tb/tb_fmps_tx_arbiter.sv
// Scoreboard bench for fmps_tx_arbiter: queued source packets, a round-robin reference model
// and a monitor that compares every presented TX word against the expected stream.
module tb_fmps_tx_arbiter;
    localparam int NS = 3;
    localparam int CW = 8;

    typedef struct {
        int          src;
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic              auroraUserClk = 1'b0;
    logic              auroraReset = 1'b0;
    logic              auroraFAstrobe = 1'b0;
    logic              auroraChannelUp = 1'b1;
    logic [32*NS-1:0]  srcTDATA = '0;
    logic [NS-1:0]     srcTVALID = '0;
    logic [NS-1:0]     srcTLAST = '0;
    logic [NS-1:0]     srcTREADY;
    logic [31:0]       txData;
    logic              txValid;
    logic              txLast;
    logic              txReady = 1'b1;
    logic [NS-1:0]     grant;
    logic [CW-1:0]     packetsLastCycle;
    logic [CW-1:0]     abortCount;

    int          total = 0;
    int          bad = 0;
    bit          randReady = 1'b0;
    int          mPtr = NS - 1;
    int          mCount = 0;
    int          seq = 0;
    logic [32:0] srcQ [NS][$];
    logic [32:0] mQ [NS][$];
    exp_t        expQ [$];

    fmps_tx_arbiter #(.NUM_SOURCES(NS), .CNT_WIDTH(CW)) dut (
        .auroraUserClk                  (auroraUserClk),
        .auroraReset                    (auroraReset),
        .auroraFAstrobe                 (auroraFAstrobe),
        .auroraChannelUp                (auroraChannelUp),
        .srcTDATA                       (srcTDATA),
        .srcTVALID                      (srcTVALID),
        .srcTLAST                       (srcTLAST),
        .srcTREADY                      (srcTREADY),
        .FMPS_TEST_AXI_STREAM_TX_tdata  (txData),
        .FMPS_TEST_AXI_STREAM_TX_tvalid (txValid),
        .FMPS_TEST_AXI_STREAM_TX_tlast  (txLast),
        .FMPS_TEST_AXI_STREAM_TX_tready (txReady),
        .grant                          (grant),
        .packetsLastCycle               (packetsLastCycle),
        .abortCount                     (abortCount)
    );

    always #5 auroraUserClk = ~auroraUserClk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, expv);
        end
    endtask

    task automatic addPacket(input int src, input int len, input bit toModel);
        logic [32:0] w;
        for (int j = 0; j < len; j++) begin
            w[31:0] = (j == 0) ? {16'hB6CF, 8'(src), 8'(seq)} : $urandom;
            w[32]   = (j == len - 1);
            srcQ[src].push_back(w);
            if (toModel) mQ[src].push_back(w);
        end
        seq++;
    endtask

    // Reference: with every loaded source continuously valid, packets leave in strict rotation
    // starting after the last owner, skipping sources that have nothing left.
    task automatic schedule();
        int          w;
        bit          any;
        bit          more;
        logic [32:0] e;
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            w = 0;
            for (int k = NS; k >= 1; k--) begin
                if (mQ[(mPtr + k) % NS].size() != 0) begin
                    any = 1'b1;
                    w = (mPtr + k) % NS;
                end
            end
            if (any) begin
                mPtr = w;
                mCount++;
                more = 1'b1;
                while (more) begin
                    e = mQ[w].pop_front();
                    expQ.push_back('{w, e[31:0], e[32]});
                    more = !e[32];
                end
            end
        end
    endtask

    task automatic waitIdle(input int maxCyc);
        int n;
        bit busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < maxCyc) begin
            @(negedge auroraUserClk);
            n++;
            busy = (grant != '0) || (expQ.size() != 0);
            for (int i = 0; i < NS; i++) if (srcQ[i].size() != 0) busy = 1'b1;
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL idle_timeout actual=busy required=idle within %0d cycles", maxCyc);
            expQ.delete();
            for (int i = 0; i < NS; i++) srcQ[i].delete();
        end
    endtask

    task automatic waitTxFire(input bit needLast, input string name);
        int n;
        bit hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 100) begin
            @(negedge auroraUserClk);
            n++;
            hit = txValid && txReady && (!needLast || txLast);
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL %s actual=no_handshake required=handshake", name);
        end
    endtask

    task automatic strobeCheck(input string name);
        @(negedge auroraUserClk);
        auroraFAstrobe = 1'b1;
        @(negedge auroraUserClk);
        auroraFAstrobe = 1'b0;
        chk(name, 64'(packetsLastCycle), 64'((mCount > 255) ? 255 : mCount));
        mCount = 0;
    endtask

    // Source drivers: handshakes are sampled mid-cycle, queues advance just after the edge.
    initial begin
        bit [NS-1:0] fire;
        forever begin
            @(negedge auroraUserClk);
            fire = srcTVALID & srcTREADY;
            @(posedge auroraUserClk);
            #1;
            for (int i = 0; i < NS; i++) begin
                if (fire[i] && srcQ[i].size() != 0) void'(srcQ[i].pop_front());
                srcTVALID[i] = (srcQ[i].size() != 0);
                if (srcQ[i].size() != 0) begin
                    srcTDATA[32*i +: 32] = srcQ[i][0][31:0];
                    srcTLAST[i]          = srcQ[i][0][32];
                end
            end
            txReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: every presented word must match the head of the expected stream.
    initial begin
        exp_t e;
        forever begin
            @(negedge auroraUserClk);
            if (!auroraReset && txValid) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word actual=%h required=no_word", txData);
                end else begin
                    e = expQ[0];
                    chk("tx_data", 64'(txData), 64'(e.data));
                    chk("tx_last", 64'(txLast), 64'(e.last));
                    chk("tx_grant", 64'(grant), 64'(NS'(1) << e.src));
                    if (txReady) void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        #1 auroraReset = 1'b1;
        repeat (3) @(negedge auroraUserClk);
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_tvalid", 64'(txValid), 64'(0));
        chk("rst_tlast", 64'(txLast), 64'(0));
        chk("rst_tdata", 64'(txData), 64'(0));
        chk("rst_srcready", 64'(srcTREADY), 64'(0));
        chk("rst_pkts", 64'(packetsLastCycle), 64'(0));
        chk("rst_abort", 64'(abortCount), 64'(0));
        @(posedge auroraUserClk);
        #3 auroraReset = 1'b0;

        // Single 2-word packet: one cycle of arbitration, two words, one idle bubble.
        @(negedge auroraUserClk);
        addPacket(0, 2, 1'b1);
        schedule();
        @(negedge auroraUserClk);
        chk("arb_idle_grant", 64'(grant), 64'(0));
        @(negedge auroraUserClk);
        chk("arb_grant", 64'(grant), 64'(1));
        chk("arb_tvalid", 64'(txValid), 64'(1));
        waitTxFire(1'b1, "single_last");
        @(negedge auroraUserClk);
        chk("bubble_grant", 64'(grant), 64'(0));
        chk("bubble_tvalid", 64'(txValid), 64'(0));
        waitIdle(50);
        strobeCheck("count_single");

        // Fairness: all sources continuously requesting.
        for (int p = 0; p < 4; p++) begin
            for (int s = 0; s < NS; s++) addPacket(s, 2, 1'b1);
        end
        schedule();
        waitIdle(300);
        strobeCheck("count_fair");

        // Random packets with random backpressure.
        randReady = 1'b1;
        for (int r = 0; r < 6; r++) begin
            @(negedge auroraUserClk);
            for (int s = 0; s < NS; s++) begin
                cnt = $urandom_range(0, 3);
                for (int p = 0; p < cnt; p++) addPacket(s, $urandom_range(1, 5), 1'b1);
            end
            schedule();
            waitIdle(1500);
            strobeCheck("count_random");
        end
        randReady = 1'b0;
        chk("abort_none", 64'(abortCount), 64'(0));

        // Channel loss after the header of a 3-word packet: flushed through FLUSH.
        @(negedge auroraUserClk);
        addPacket(1, 3, 1'b0);
        expQ.push_back('{1, srcQ[1][0][31:0], 1'b0});
        mPtr = 1;
        waitTxFire(1'b0, "drop3_header");
        @(posedge auroraUserClk);
        #2 auroraChannelUp = 1'b0;
        #1;
        chk("drop3_tvalid", 64'(txValid), 64'(0));
        chk("drop3_srcready", 64'(srcTREADY[1]), 64'(1));
        @(negedge auroraUserClk);
        @(negedge auroraUserClk);
        chk("drop3_flush_grant", 64'(grant), 64'(2));
        waitIdle(50);
        chk("drop3_abort", 64'(abortCount), 64'(1));
        @(negedge auroraUserClk);
        chk("down_drain_ready", 64'(srcTREADY), 64'({NS{1'b1}}));
        chk("down_no_grant", 64'(grant), 64'(0));

        // Channel loss while the owner presents its last word: straight back to IDLE.
        auroraChannelUp = 1'b1;
        @(negedge auroraUserClk);
        addPacket(2, 2, 1'b0);
        expQ.push_back('{2, srcQ[2][0][31:0], 1'b0});
        mPtr = 2;
        waitTxFire(1'b0, "drop2_header");
        @(posedge auroraUserClk);
        #2 auroraChannelUp = 1'b0;
        #1;
        chk("drop2_tvalid", 64'(txValid), 64'(0));
        @(negedge auroraUserClk);
        @(negedge auroraUserClk);
        chk("drop2_idle_grant", 64'(grant), 64'(0));
        waitIdle(50);
        chk("drop2_abort", 64'(abortCount), 64'(2));
        auroraChannelUp = 1'b1;
        @(negedge auroraUserClk);
        addPacket(0, 3, 1'b1);
        addPacket(1, 2, 1'b1);
        schedule();
        waitIdle(100);
        strobeCheck("count_after_abort");

        // Packet counter saturation.
        @(negedge auroraUserClk);
        for (int p = 0; p < 100; p++) begin
            for (int s = 0; s < NS; s++) addPacket(s, 1, 1'b1);
        end
        schedule();
        waitIdle(2000);
        strobeCheck("count_saturate");

        // Packet completing on the strobe cycle starts the next interval.
        @(negedge auroraUserClk);
        addPacket(0, 2, 1'b1);
        addPacket(2, 3, 1'b1);
        schedule();
        waitIdle(100);
        addPacket(1, 1, 1'b1);
        schedule();
        waitTxFire(1'b1, "coincident_last");
        auroraFAstrobe = 1'b1;
        @(negedge auroraUserClk);
        auroraFAstrobe = 1'b0;
        chk("coincident_excluded", 64'(packetsLastCycle), 64'(2));
        mCount = 1;
        waitIdle(50);
        strobeCheck("coincident_restart");

        // Asynchronous reset in the middle of a packet.
        @(negedge auroraUserClk);
        addPacket(1, 6, 1'b1);
        schedule();
        cnt = 0;
        for (int n = 0; n < 50 && cnt < 3; n++) begin
            @(negedge auroraUserClk);
            if (txValid && txReady) cnt++;
        end
        chk("midpkt_words", 64'(cnt), 64'(3));
        @(posedge auroraUserClk);
        #3 auroraReset = 1'b1;
        #1;
        chk("arst_grant", 64'(grant), 64'(0));
        chk("arst_tvalid", 64'(txValid), 64'(0));
        chk("arst_srcready", 64'(srcTREADY), 64'(0));
        chk("arst_pkts", 64'(packetsLastCycle), 64'(0));
        chk("arst_abort", 64'(abortCount), 64'(0));
        for (int i = 0; i < NS; i++) srcQ[i].delete();
        expQ.delete();
        mPtr = NS - 1;
        mCount = 0;
        repeat (2) @(posedge auroraUserClk);
        #3 auroraReset = 1'b0;
        @(negedge auroraUserClk);
        addPacket(2, 2, 1'b1);
        addPacket(1, 2, 1'b1);
        addPacket(0, 2, 1'b1);
        schedule();
        @(negedge auroraUserClk);
        @(negedge auroraUserClk);
        chk("post_rst_first_grant", 64'(grant), 64'(1));
        waitIdle(100);
        strobeCheck("count_post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fmps_tx_arbiter.md
# fmps_tx_arbiter

Packet-granular round-robin arbiter that shares one FMPS Aurora TX AXI-Stream link between several packet sources, e.g. multiple FMPS test/data streamers. It sits between the sources and the Aurora TX user interface in the auroraUserClk domain. It keeps every packet atomic, gates traffic on auroraChannelUp, and discards in-flight traffic cleanly when the channel drops. It also reports per-FA-cycle packet counts for monitoring.

## Interface
- NUM_SOURCES, 2: number of requesting AXIS sources, 2..8.
- CNT_WIDTH, 8: width of packet and abort counters.

- auroraUserClk  in  1  sole clock; all logic on rising edge.
- auroraReset  in  1  asynchronous, active-high reset.
- auroraFAstrobe  in  1  single-cycle FA cycle marker.
- auroraChannelUp  in  1  Aurora channel up, level.
- srcTDATA  in  32*NUM_SOURCES  source data; source i at bits [32*i+31:32*i].
- srcTVALID  in  NUM_SOURCES  per-source valid.
- srcTLAST  in  NUM_SOURCES  per-source last.
- srcTREADY  out  NUM_SOURCES  per-source ready.
- FMPS_TEST_AXI_STREAM_TX_tdata  out  32  link data.
- FMPS_TEST_AXI_STREAM_TX_tvalid  out  1  link valid.
- FMPS_TEST_AXI_STREAM_TX_tlast  out  1  link last.
- FMPS_TEST_AXI_STREAM_TX_tready  in  1  link ready.
- grant  out  NUM_SOURCES  one-hot current owner; 0 when none.
- packetsLastCycle  out  CNT_WIDTH  packets completed during previous FA interval.
- abortCount  out  CNT_WIDTH  saturating count of packets cut by channel loss.

## Operation
- States: IDLE, SEND, FLUSH.
- Reset values:
  - state=IDLE, grant=0, rrPointer=NUM_SOURCES-1.
  - All counters 0, all srcTREADY 0.
  - TX tvalid 0, tlast 0, tdata 0.
- IDLE:
  - Applies when auroraChannelUp=1 and some srcTVALID is high.
  - Selects the first requester scanning rrPointer+1, rrPointer+2, … modulo NUM_SOURCES.
  - Registers the one-hot grant, sets rrPointer to the winner and moves to SEND.
  - When auroraChannelUp=0, all srcTREADY=1: sources drain and their data is discarded. No grant is issued.
- SEND:
  - TX tdata/tvalid/tlast = granted source's tdata/tvalid/tlast, combinational mux.
  - Granted srcTREADY = TX tready; all others 0.
  - On the handshake (tvalid & tready & tlast): packet counter increments, grant clears, next state is IDLE.
  - If auroraChannelUp falls while in SEND:
    - TX tvalid is forced to 0 that same cycle.
    - abortCount increments, saturating at all-ones.
    - If the current source word carries TLAST with TVALID high, go to IDLE. Otherwise go to FLUSH.
- FLUSH:
  - Granted srcTREADY=1 and TX tvalid=0.
  - Remaining words of the packet are discarded.
  - On the granted source's TLAST&TVALID, grant clears and next state is IDLE.
- Packet counting:
  - On auroraFAstrobe, packetsLastCycle ← current count and the count restarts.
  - If a packet completes in the same cycle as the strobe, the count restarts at 1 and that packet is not included in packetsLastCycle.
  - Count saturates at all-ones.
- Arithmetic: rrPointer is $clog2(NUM_SOURCES) bits and wraps modulo NUM_SOURCES, including non-power-of-two counts.

## Timing
- Arbitration latency: source tvalid seen in IDLE → grant and TX tvalid on the next cycle. Minimum one cycle from request to first word.
- One mandatory IDLE bubble between consecutive packets, which yields max throughput of L/(L+1) for L-word packets.
- Data path is combinational: no added latency per word and no buffering. AXIS rules hold: the held word stays stable while tvalid=1 and tready=0.
- The grant never changes mid-packet, whatever the other sources request.
- Channel loss takes effect in the same cycle on TX tvalid. Channel return is honored only from IDLE.
- auroraReset mid-packet:
  - Outputs return to reset values immediately (asynchronous).
  - The partially sent packet is not counted.
  - The downstream Aurora core handles frame truncation.

## Test plan
- Single source, NUM_SOURCES=2:
  - Stimulus: source 0 sends a 2-word packet (header 0xB6CF…, 1 data word), tready constantly 1.
  - Response: grant=01 one cycle after tvalid; both words appear unchanged; tlast on word 2; IDLE one cycle.
- Round-robin fairness:
  - Stimulus: both sources continuously valid for 10 packets.
  - Response: grants alternate 01,10,01…; each source gets 5; no interleaved words.
- Backpressure:
  - Stimulus: tready is random with probability 0.5.
  - Response: every word is transferred once, in order; data and tlast are held stable while stalled; packet count matches the number sent.
- Channel down mid-packet:
  - Stimulus: drop auroraChannelUp after the header handshake of a 3-word packet.
  - Response: TX tvalid=0 the same cycle; remaining words are absorbed in FLUSH; abortCount=1; the next packet after channel up is complete.
- Per-cycle counting:
  - Stimulus: strobe every 200 cycles, 3 packets per interval; one packet's TLAST handshake coincides with the strobe.
  - Response: packetsLastCycle=3 normally. On the coincident strobe, packetsLastCycle excludes that packet and the counter restarts at 1.
- Async reset during SEND:
  - Response: grant=0, TX tvalid=0 and srcTREADY=0 immediately.
  - After release: IDLE, rrPointer=NUM_SOURCES-1, so source 0 wins the first arbitration.
